seq_detect_sched: RTL and testbench

Bit-serial pattern-detection scheduler that accepts parallel words from one upstream requester over a valid/ready handshake and shifts them MSB-first, one bit per clock, through a programmable overlapping pattern matcher.
- Counts matches and raises a sticky threshold flag.
- Holds the pattern configuration, pattern length and threshold, which are writable only while idle.
- Sits between a word-wide source and the serial sequence-detection logic; it sequences and configures that logic.

---
 rtl/seq_detect_sched.sv | 146 ++++++++++++++
 tb/tb_seq_detect_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_sched.sv
// Bit-serial pattern-detection scheduler: accepts words over valid/ready, shifts them MSB-first
// through a programmable pattern matcher. Define SEQ_SCHED_NOOVL_EN for non-overlapping detection.
`timescale 1ns/1ps

module seq_detect_sched #(
  parameter int DATA_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               clr_cnt,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               busy,
  output logic               bit_out,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               thresh_hit
);

  localparam int         IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [3:0] LEN_MAX = 4'(PAT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_shreg;
  logic [IDX_W-1:0]    r_idx;
  logic [PAT_MAX-1:0]  r_hist;
  logic [3:0]          r_fill;
  logic [PAT_MAX-1:0]  r_pattern;
  logic [3:0]          r_len;
  logic [CNT_W-1:0]    r_thresh;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_seq_seen;
  logic                r_thresh_hit;

  logic                w_bit;
  logic [PAT_MAX-1:0]  w_hist_nxt;
  logic [3:0]          w_fill_nxt;
  logic [PAT_MAX-1:0]  w_mask;
  logic                w_match;
  logic [3:0]          w_len_clamped;
  logic [CNT_W-1:0]    w_cnt_inc;

  assign w_bit      = r_shreg[DATA_W-1];
  assign w_hist_nxt = {r_hist[PAT_MAX-2:0], w_bit};
  assign w_fill_nxt = (r_fill >= LEN_MAX) ? LEN_MAX : r_fill + 4'd1;
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  assign w_len_clamped = (cfg_len == 4'd0)    ? 4'd1    :
                         (cfg_len > LEN_MAX)  ? LEN_MAX : cfg_len;

  // NOTE: default every combinational output before the loop so no path leaves it unassigned (latch).
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      w_mask[i] = (4'(i) < r_len);
    end
  end

  // A match is judged on the history as it will be after absorbing the current bit.
  assign w_match = (r_state == S_SHIFT) && en &&
                   (((w_hist_nxt ^ r_pattern) & w_mask) == '0) &&
                   (w_fill_nxt >= r_len);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_idx        <= '0;
      r_hist       <= '0;
      r_fill       <= '0;
      r_pattern    <= PAT_MAX'(4'b1011);
      r_len        <= 4'd4;
      r_thresh     <= '0;
      r_cnt        <= '0;
      r_seq_seen   <= 1'b0;
      r_thresh_hit <= 1'b0;
    end else begin
      r_seq_seen <= w_match;

      // Clear beats a coincident match; the pulse itself still fires.
      if (clr_cnt) begin
        r_cnt        <= '0;
        r_thresh_hit <= 1'b0;
      end else if (w_match) begin
        r_cnt <= w_cnt_inc;
        if ((r_thresh != '0) && (w_cnt_inc == r_thresh)) r_thresh_hit <= 1'b1;
      end

      if ((r_state == S_IDLE) && cfg_we) begin
        r_pattern <= cfg_pattern;
        r_len     <= w_len_clamped;
        r_thresh  <= cfg_thresh;
      end

      if (!en) begin
        r_state <= S_IDLE;
        r_shreg <= '0;
        r_idx   <= '0;
        r_hist  <= '0;
        r_fill  <= '0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_WAIT;
          S_WAIT: begin
            if (in_valid) begin
              r_shreg <= in_data;
              r_idx   <= '0;
              r_state <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
            r_hist  <= w_hist_nxt;
`ifdef SEQ_SCHED_NOOVL_EN
            r_fill  <= w_match ? 4'd0 : w_fill_nxt;
`else
            r_fill  <= w_fill_nxt;
`endif
            r_idx   <= r_idx + IDX_W'(1);
            if (r_idx == IDX_W'(DATA_W - 1)) r_state <= S_WAIT;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign in_ready   = (r_state == S_WAIT);
  assign busy       = (r_state == S_SHIFT);
  assign bit_out    = (r_state == S_SHIFT) & w_bit;
  assign seq_seen   = r_seq_seen;
  assign match_cnt  = r_cnt;
  assign thresh_hit = r_thresh_hit;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Self-checking bench for seq_detect_sched: expected seq_seen pulses are queued per word
// and popped cycle by cycle as the DUT shifts; count and threshold are tracked alongside.
`timescale 1ns/1ps

module tb_seq_detect_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic [7:0] cfg_thresh = '0;
  logic       clr_cnt = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, busy, bit_out, seq_seen, thresh_hit;
  logic [7:0] match_cnt;

  int         checks = 0;
  int         failures = 0;
  bit         exp_q[$];
  logic [7:0] exp_cnt = '0;
  logic       exp_th = 1'b0;
  logic [7:0] exp_thr = '0;

  seq_detect_sched #(.DATA_W(8), .PAT_MAX(8), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_thresh (cfg_thresh),
    .clr_cnt    (clr_cnt),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .busy       (busy),
    .bit_out    (bit_out),
    .seq_seen   (seq_seen),
    .match_cnt  (match_cnt),
    .thresh_hit (thresh_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go_idle();
    en = 1'b0;
    step();
  endtask

  task automatic enable();
    en = 1'b1;
    step();
  endtask

  task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] thr);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_thresh = thr;
    step();
    cfg_we = 1'b0;
    exp_thr = thr;
  endtask

  task automatic clear_counts();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    exp_cnt = '0;
    exp_th  = 1'b0;
    checks++;
    if (match_cnt !== 8'd0 || thresh_hit !== 1'b0) begin
      failures++;
      $display("FAIL clr_cnt: match_cnt=%0d thresh_hit=%0b, want 0/0", match_cnt, thresh_hit);
    end
  endtask

  // Called at a negedge with the DUT in WAIT (or about to be); returns at the negedge after the last bit.
  task automatic send_word(input logic [7:0] d, input logic [7:0] mask, input string tag);
    int  guard = 0;
    bit  e;
    in_data  = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s handshake: in_ready=%b, want 1 within 20 cycles", tag, in_ready);
      in_valid = 1'b0;
      return;
    end
    for (int k = 0; k < 8; k++) exp_q.push_back(mask[k]);
    step();
    in_valid = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        checks++;
        if (busy !== 1'b1 || bit_out !== d[7-k]) begin
          failures++;
          $display("FAIL %s shift bit%0d: busy=%b bit_out=%b, want 1/%b", tag, k, busy, bit_out, d[7-k]);
        end
      end
      if (k > 0) begin
        e = exp_q.pop_front();
        if (e) begin
          if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
          if (exp_thr != 8'd0 && exp_cnt == exp_thr) exp_th = 1'b1;
        end
        checks++;
        if (seq_seen !== e || match_cnt !== exp_cnt || thresh_hit !== exp_th) begin
          failures++;
          $display("FAIL %s after bit%0d: seq_seen=%b cnt=%0d th=%b, want %b/%0d/%b",
                   tag, k - 1, seq_seen, match_cnt, thresh_hit, e, exp_cnt, exp_th);
        end
      end
      if (k < 8) step();
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s end: busy=%b in_ready=%b, want 0/1", tag, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if ({in_ready, busy, bit_out, seq_seen, thresh_hit} !== 5'b0 || match_cnt !== 8'd0) begin
        failures++;
        $display("FAIL reset idle cyc%0d: rdy/busy/bit/seen/th=%b cnt=%0d, want 0",
                 c, {in_ready, busy, bit_out, seq_seen, thresh_hit}, match_cnt);
      end
    end
    enable();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL enable: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_default_pattern();
    clear_counts();
`ifdef SEQ_SCHED_NOOVL_EN
    send_word(8'hB6, 8'h08, "default_pattern");
`else
    send_word(8'hB6, 8'h48, "default_pattern");
`endif
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_word(8'h01, 8'h00, "b2b_w1");
    send_word(8'h60, 8'h04, "b2b_w2");
  endtask

  task automatic test_threshold();
    clear_counts();
    go_idle();
    cfg_write(8'h0B, 4'd4, 8'd3);
    enable();
    send_word(8'hBB, 8'h88, "thresh_w1");
    send_word(8'hB0, 8'h08, "thresh_w2");
    step();
    checks++;
    if (thresh_hit !== 1'b1 || match_cnt !== 8'd3) begin
      failures++;
      $display("FAIL thresh sticky: th=%b cnt=%0d, want 1/3", thresh_hit, match_cnt);
    end
    clear_counts();
  endtask

  task automatic test_abort();
    in_data  = 8'hB0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (busy !== 1'b1 || bit_out !== ((k == 0) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL abort shift bit%0d: busy=%b bit_out=%b", k, busy, bit_out);
      end
      step();
    end
    en = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || seq_seen !== 1'b0 || match_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL abort idle: busy=%b rdy=%b seen=%b cnt=%0d, want 0/0/0/%0d",
               busy, in_ready, seq_seen, match_cnt, exp_cnt);
    end
    enable();
    send_word(8'h0B, 8'h80, "abort_resume");
  endtask

  task automatic test_cfg_busy();
    cfg_we = 1'b1; cfg_pattern = 8'h07; cfg_len = 4'd3; cfg_thresh = 8'd0;
    send_word(8'hB0, 8'h08, "cfg_ignored");
    cfg_we = 1'b0;
    go_idle();
    cfg_write(8'h07, 4'd3, 8'd0);
    enable();
`ifdef SEQ_SCHED_NOOVL_EN
    send_word(8'hF0, 8'h04, "cfg_111");
`else
    send_word(8'hF0, 8'h0C, "cfg_111");
`endif
  endtask

  task automatic test_saturation();
    go_idle();
    cfg_write(8'h01, 4'd0, 8'd0);
    enable();
    clear_counts();
    for (int w = 0; w < 33; w++) send_word(8'hFF, 8'hFF, "saturate");
    checks++;
    if (match_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL saturate final: cnt=%0d, want 255", match_cnt);
    end
  endtask

  task automatic test_async_reset();
    in_data  = 8'hB6;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, busy, bit_out, seq_seen, thresh_hit} !== 5'b0 || match_cnt !== 8'd0) begin
      failures++;
      $display("FAIL async_reset: rdy/busy/bit/seen/th=%b cnt=%0d, want 0",
               {in_ready, busy, bit_out, seq_seen, thresh_hit}, match_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    en = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_default_pattern();
    test_back_to_back();
    test_threshold();
    test_abort();
    test_cfg_busy();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
